multi_event_handshake_tx: RTL and testbench

- Source-side front end for cross-clock event transfer with NUM_CH independent event channels.
- Counts single-cycle event pulses per channel, so an event is queued rather than lost while a transfer is in flight.
- Drains queued events one at a time, using round-robin arbitration, through a 4-phase req/ack handshake to a receiver in a foreign clock domain.
- Resynchronises the returning ack internally. Sits between local event producers and the crossing synchroniser / remote receiver.

---
 rtl/multi_event_handshake_tx.sv | 159 +++++++++++++++
 tb/tb_multi_event_handshake_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_event_handshake_tx.sv
// Source side of a multi-channel event crossing. Each channel counts
// single-cycle event pulses and the queued events are drained one at a time,
// round robin, over a 4-phase req/ack handshake to a foreign clock domain.

// Pending-event counter for one channel.
// It saturates at its maximum value and flags any event dropped at saturation.
module multi_event_handshake_tx_ch #(
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nz,
    output logic ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;

    // Count update. inc and dec in the same cycle cancel out. The arbiter
    // only grants a channel with a non-zero count, so dec never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            nz  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (inc && !dec) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                    nz  <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (dec && !inc) begin
                cnt <= cnt - CNT_W'(1);
                nz  <= (cnt != CNT_W'(1));
            end
        end
    end

endmodule

module multi_event_handshake_tx #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 3,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ev_in,
    output logic              req,
    output logic [CH_W-1:0]   ch_id,
    input  logic              ack,
    output logic [NUM_CH-1:0] pend_nz,
    output logic [NUM_CH-1:0] ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [CH_W-1:0]        rr_ptr;
    logic                   grant_vld;
    logic [CH_W-1:0]        grant_ch;
    logic                   do_grant;
    logic                   do_release;

    // Ack resynchroniser. Only the last stage is used by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Per-channel counters. pend_nz is the registered non-zero flag, so the
    // arbiter can search it directly.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_event_handshake_tx_ch #(.CNT_W(CNT_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (ev_in[i]),
            .dec   (do_grant && (grant_ch == CH_W'(i))),
            .nz    (pend_nz[i]),
            .ovf   (ovf[i])
        );
    end

    // Round-robin search. Find the first pending channel at or after rr_ptr,
    // wrapping past the last channel.
    always_comb begin
        int              idx_i;
        logic [CH_W-1:0] idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx_i     = 0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_i = (int'(rr_ptr) + k) % NUM_CH;
            idx   = CH_W'(idx_i);
            if (!grant_vld && pend_nz[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state. A stuck-high ack_s in IDLE blocks new grants.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_vld && !ack_s) state_nxt = REQ;
            REQ:     if (ack_s)               state_nxt = RELEASE;
            RELEASE: if (!ack_s)              state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy       = (state != IDLE);
        do_grant   = (state == IDLE) && !ack_s && grant_vld;
        do_release = (state == REQ) && ack_s;
    end

    // Handshake registers. ch_id only changes on a grant, so it is stable
    // for the whole time req is high and it keeps its value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req    <= 1'b0;
            ch_id  <= '0;
            rr_ptr <= '0;
        end else if (do_grant) begin
            req    <= 1'b1;
            ch_id  <= grant_ch;
            rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        end else if (do_release) begin
            req    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_event_handshake_tx.sv
// Randomised bench for multi_event_handshake_tx. A remote responder answers
// req with random delays. A per-cycle reference model, built from the
// channel counts and handshake phases, predicts every output.
module tb_multi_event_handshake_tx;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 3;
    localparam int SYNC   = 2;
    localparam int CH_W   = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ev_in;
    logic              req;
    logic [CH_W-1:0]   ch_id;
    logic              ack;
    logic [NUM_CH-1:0] pend_nz;
    logic [NUM_CH-1:0] ovf;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int                m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;
    int                m_rr;
    int                m_ph;   // 0 idle, 1 waiting for ack, 2 waiting for ack release
    logic              m_req;
    int                m_ch;
    bit                m_sync [SYNC];

    // remote responder state
    bit force_ack;
    int rsp_wait;

    multi_event_handshake_tx #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ev_in   (ev_in),
        .req     (req),
        .ch_id   (ch_id),
        .ack     (ack),
        .pend_nz (pend_nz),
        .ovf     (ovf),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        for (int s = 0; s < SYNC; s++) m_sync[s] = 1'b0;
        m_ovf = '0; m_rr = 0; m_ph = 0; m_req = 1'b0; m_ch = 0;
        force_ack = 1'b0; rsp_wait = 0;
    endtask

    function automatic logic [NUM_CH-1:0] exp_nz();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] rnd_ev(input int dens);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = ($urandom_range(0, 99) < dens);
        return v;
    endfunction

    // Advance the model across one clock edge, given the inputs for that edge.
    task automatic model_edge(input logic [NUM_CH-1:0] ev_v, input logic ack_v);
        bit acks;
        int g;
        int c;
        acks = m_sync[SYNC-1];
        g = -1;
        if (m_ph == 0 && !acks)
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_rr + k) % NUM_CH;
                if (g < 0 && m_cnt[c] > 0) g = c;
            end
        for (int i = 0; i < NUM_CH; i++) begin
            m_ovf[i] = 1'b0;
            if (ev_v[i] && g != i) begin
                if (m_cnt[i] < CMAX) m_cnt[i]++;
                else                 m_ovf[i] = 1'b1;
            end else if (!ev_v[i] && g == i) begin
                m_cnt[i]--;
            end
        end
        case (m_ph)
            0: if (g >= 0) begin m_ph = 1; m_req = 1'b1; m_ch = g; m_rr = (g + 1) % NUM_CH; end
            1: if (acks)   begin m_ph = 2; m_req = 1'b0; end
            2: if (!acks)  m_ph = 0;
            default: m_ph = 0;
        endcase
        for (int s = SYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
        m_sync[0] = ack_v;
    endtask

    // One cycle: check outputs, run the remote responder, step the model,
    // then drive the inputs and wait for the next edge.
    task automatic cycle(input logic [NUM_CH-1:0] ev_v);
        logic ack_v;
        chk("req", req, m_req);
        chk("ch_id", ch_id, m_ch);
        chk("pend_nz", pend_nz, exp_nz());
        chk("ovf", ovf, m_ovf);
        chk("busy", busy, m_ph != 0);
        ack_v = ack;
        if (force_ack) begin
            ack_v = 1'b1;
        end else if (!ack && req) begin
            if (rsp_wait == 0) begin ack_v = 1'b1; rsp_wait = $urandom_range(0, 3); end
            else rsp_wait--;
        end else if (ack && !req) begin
            if (rsp_wait == 0) begin ack_v = 1'b0; rsp_wait = $urandom_range(0, 3); end
            else rsp_wait--;
        end
        model_edge(ev_v, ack_v);
        ev_in = ev_v;
        ack   = ack_v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ev_in = '0;
        ack   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, 1'b0);
        chk("rst_ch_id", ch_id, '0);
        chk("rst_pend_nz", pend_nz, '0);
        chk("rst_ovf", ovf, '0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // single event on channel 0, then let it drain
        cycle(4'b0001);
        repeat (30) cycle('0);

        // random sparse traffic
        repeat (400) cycle(rnd_ev(20));
        repeat (100) cycle('0);

        // saturation: ack held high blocks grants while ch1 fills past its limit
        force_ack = 1'b1;
        repeat (6) cycle('0);
        repeat (9) cycle(4'b0010);
        force_ack = 1'b0;
        repeat (150) cycle('0);

        // heavy traffic on all channels
        repeat (300) cycle(rnd_ev(70));

        // reset while a request is outstanding
        for (int n = 0; n < 60 && m_ph != 1; n++) cycle(rnd_ev(50));
        chk("reach_req_phase", m_ph, 1);
        rst_n = 1'b0;
        ev_in = '0;
        ack   = 1'b0;
        #1;
        chk("midrst_req", req, 1'b0);
        chk("midrst_pend_nz", pend_nz, '0);
        chk("midrst_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) cycle('0);
        cycle(4'b0100);
        repeat (40) cycle('0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
